// File: rtl/soc_evt_pkg.sv
// Shared types and constants for the SoC-to-cluster event bridge.
package soc_evt_pkg;

  localparam int unsigned EvtWidth = 8;
  typedef logic [EvtWidth-1:0] evt_t;

  // Default base event codes of the SoC-side producers.
  localparam evt_t DmaPeEvtId = 8'd0;
  localparam evt_t DmaPeIrqId = 8'd1;
  localparam evt_t PfEvtId    = 8'd2;

  // Width of a counter that can hold 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins.
module soc_evt_rr_arb #(
  parameter  int unsigned NB_CH = 3,
  localparam int unsigned IdxW  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic [NB_CH-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NB_CH-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  logic [2*NB_CH-1:0] req2;
  logic [NB_CH-1:0]   rot;
  logic [IdxW-1:0]    off;
  logic [IdxW:0]      sum;

  always_comb begin
    valid_o = 1'b0;
    off     = '0;
    // Rotate so bit 0 of rot is the channel at the RR pointer.
    req2    = {req_i, req_i};
    rot     = req2[ptr_i +: NB_CH];
    for (int i = 0; i < NB_CH; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        off     = IdxW'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IdxW + 1)'(NB_CH)) begin
      sum = sum - (IdxW + 1)'(NB_CH);
    end
    idx_o = sum[IdxW-1:0];
    gnt_o = valid_o ? (NB_CH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/soc_evt_bridge.sv
// Round-robin event collector writing a wt/rp toggle token buffer.
// Optional SOC_EVT_BRIDGE_RP_SYNC_EN: 2-flop synchroniser on events_rp_i.
module soc_evt_bridge
  import soc_evt_pkg::*;
#(
  parameter int unsigned NB_CH        = 3,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned EVT_WIDTH    = 8,
  parameter int unsigned EVT_ID_BASE  = 32'(DmaPeEvtId)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NB_CH-1:0]                  evt_valid_i,
  output logic [NB_CH-1:0]                  evt_ack_o,
  output logic [BUFFER_DEPTH-1:0]           events_wt_o,
  input  logic [BUFFER_DEPTH-1:0]           events_rp_i,
  output logic [BUFFER_DEPTH*EVT_WIDTH-1:0] events_da_o,
  output logic [$clog2(BUFFER_DEPTH):0]     occupancy_o,
  output logic                              full_o
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned IdxW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int unsigned OccW = occ_width(BUFFER_DEPTH);

  logic [BUFFER_DEPTH-1:0]                wt_q, wt_d;
  logic [BUFFER_DEPTH-1:0][EVT_WIDTH-1:0] da_q, da_d;
  logic [PtrW-1:0]                        wptr_q, wptr_d;
  logic [IdxW-1:0]                        rr_q, rr_d;
  logic [NB_CH-1:0]                       ack_q, ack_d;
  logic [OccW-1:0]                        occ_q, occ_d;

  logic [BUFFER_DEPTH-1:0] rp_eff;
  logic [BUFFER_DEPTH-1:0] full_vec;
  logic [NB_CH-1:0]        eligible;
  logic [NB_CH-1:0]        arb_gnt;
  logic [IdxW-1:0]         arb_idx;
  logic                    arb_valid;
  logic                    grant;

`ifdef SOC_EVT_BRIDGE_RP_SYNC_EN
  logic [BUFFER_DEPTH-1:0] rp_meta_q, rp_sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp_meta_q <= '0;
      rp_sync_q <= '0;
    end else begin
      rp_meta_q <= events_rp_i;
      rp_sync_q <= rp_meta_q;
    end
  end

  assign rp_eff = rp_sync_q;
`else
  assign rp_eff = events_rp_i;
`endif

  // The registered ack doubles as the mask: a channel seeing its ack cannot win again.
  assign eligible = evt_valid_i & ~ack_q;

  soc_evt_rr_arb #(
    .NB_CH (NB_CH)
  ) u_arb (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    full_vec = wt_q ^ rp_eff;
    full_o   = full_vec[wptr_q];
    grant    = arb_valid & ~full_o;

    wt_d   = wt_q;
    da_d   = da_q;
    wptr_d = wptr_q;
    rr_d   = rr_q;
    ack_d  = '0;

    occ_d = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      occ_d = occ_d + OccW'(full_vec[k]);
    end

    if (grant) begin
      wt_d[wptr_q] = ~wt_q[wptr_q];
      da_d[wptr_q] = EVT_WIDTH'(EVT_ID_BASE) + EVT_WIDTH'(arb_idx);
      wptr_d       = wptr_q + PtrW'(1);
      rr_d         = (arb_idx == IdxW'(NB_CH - 1)) ? '0 : arb_idx + IdxW'(1);
      ack_d        = arb_gnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wt_q   <= '0;
      da_q   <= '0;
      wptr_q <= '0;
      rr_q   <= '0;
      ack_q  <= '0;
      occ_q  <= '0;
    end else begin
      wt_q   <= wt_d;
      da_q   <= da_d;
      wptr_q <= wptr_d;
      rr_q   <= rr_d;
      ack_q  <= ack_d;
      occ_q  <= occ_d;
    end
  end

  assign evt_ack_o   = ack_q;
  assign events_wt_o = wt_q;
  assign events_da_o = da_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_soc_evt_bridge.sv
// Directed self-checking bench for soc_evt_bridge at default parameters.
module tb_soc_evt_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  evt_valid_i;
  logic [2:0]  evt_ack_o;
  logic [7:0]  events_wt_o;
  logic [7:0]  events_rp_i;
  logic [63:0] events_da_o;
  logic [3:0]  occupancy_o;
  logic        full_o;

  int n_checks = 0;
  int n_errs   = 0;

`ifdef SOC_EVT_BRIDGE_RP_SYNC_EN
  localparam int FreeLat = 3;
`else
  localparam int FreeLat = 1;
`endif

  soc_evt_bridge #(
    .NB_CH        (3),
    .BUFFER_DEPTH (8),
    .EVT_WIDTH    (8),
    .EVT_ID_BASE  (0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .evt_valid_i (evt_valid_i),
    .evt_ack_o   (evt_ack_o),
    .events_wt_o (events_wt_o),
    .events_rp_i (events_rp_i),
    .events_da_o (events_da_o),
    .occupancy_o (occupancy_o),
    .full_o      (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    evt_valid_i = '0;
    events_rp_i = '0;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int          acks;
    int          lat;
    logic [7:0]  prev_wt;
    logic [2:0]  seen;

    rst_i       = 1'b1;
    evt_valid_i = '0;
    events_rp_i = '0;
    repeat (2) step();
    check_eq("rst_ack", 64'(evt_ack_o), 64'h0);
    check_eq("rst_wt", 64'(events_wt_o), 64'h0);
    check_eq("rst_da", events_da_o, 64'h0);
    check_eq("rst_occ", 64'(occupancy_o), 64'h0);
    check_eq("rst_full", 64'(full_o), 64'h0);
    rst_i = 1'b0;

    // Single event on ch1.
    evt_valid_i = 3'b010;
    step();
    evt_valid_i = '0;
    check_eq("t1_ack", 64'(evt_ack_o), 64'h2);
    check_eq("t1_wt", 64'(events_wt_o), 64'h01);
    check_eq("t1_da0", 64'(events_da_o[7:0]), 64'h01);
    check_eq("t1_occ_lag", 64'(occupancy_o), 64'h0);
    step();
    check_eq("t1_occ", 64'(occupancy_o), 64'h1);
    check_eq("t1_ack_pulse", 64'(evt_ack_o), 64'h0);
    events_rp_i = 8'h01;
    repeat (3) step();
    check_eq("t1_drain_occ", 64'(occupancy_o), 64'h0);

    // All channels, consumer tracking wt.
    do_reset();
    evt_valid_i = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("t2_ack%0d", i), 64'(evt_ack_o), 64'(3'b001 << (i % 3)));
      events_rp_i = events_wt_o;
    end
    evt_valid_i = '0;
    check_eq("t2_da", events_da_o, 64'h0100020100020100);
    check_eq("t2_wt", 64'(events_wt_o), 64'hFF);

    // Fill with ch0, consumer stalled.
    do_reset();
    evt_valid_i = 3'b001;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (evt_ack_o == 3'b001) acks++;
    end
    check_eq("t3_acks", 64'(acks), 64'd8);
    check_eq("t3_occ", 64'(occupancy_o), 64'd8);
    check_eq("t3_full", 64'(full_o), 64'h1);
    seen = '0;
    repeat (3) begin
      step();
      seen = seen | evt_ack_o;
    end
    check_eq("t3_no_ack_full", 64'(seen), 64'h0);
    events_rp_i = 8'h01;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (evt_ack_o != '0) begin
        lat = i;
        break;
      end
    end
    check_eq("t6_free_lat", 64'(lat), 64'(FreeLat));
    check_eq("t3_ack_after_free", 64'(evt_ack_o), 64'h1);
    check_eq("t3_wt_rewrite", 64'(events_wt_o), 64'hFE);
    check_eq("t3_da0", 64'(events_da_o[7:0]), 64'h00);
    evt_valid_i = '0;

    // Wrap-around, consumer drains one cycle behind.
    do_reset();
    evt_valid_i = 3'b111;
    prev_wt     = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq($sformatf("t4_ack%0d", i), 64'(evt_ack_o), 64'(3'b001 << (i % 3)));
      check_eq($sformatf("t4_da%0d", i), 64'(events_da_o[(i % 8) * 8 +: 8]), 64'(i % 3));
      events_rp_i = prev_wt;
      prev_wt     = events_wt_o;
    end
    evt_valid_i = '0;
    check_eq("t4_wt", 64'(events_wt_o), 64'h0F);

    // Reset with buffered events and ch2 pending.
    do_reset();
    evt_valid_i = 3'b011;
    repeat (5) step();
    check_eq("t5_wt_pre", 64'(events_wt_o), 64'h1F);
    evt_valid_i = 3'b100;
    rst_i       = 1'b1;
    events_rp_i = '0;
    step();
    rst_i = 1'b0;
    check_eq("t5_rst_ack", 64'(evt_ack_o), 64'h0);
    check_eq("t5_rst_wt", 64'(events_wt_o), 64'h0);
    check_eq("t5_rst_da", events_da_o, 64'h0);
    check_eq("t5_rst_occ", 64'(occupancy_o), 64'h0);
    check_eq("t5_rst_full", 64'(full_o), 64'h0);
    step();
    evt_valid_i = '0;
    check_eq("t5_ack_ch2", 64'(evt_ack_o), 64'h4);
    check_eq("t5_da0", 64'(events_da_o[7:0]), 64'h02);
    check_eq("t5_wt", 64'(events_wt_o), 64'h01);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
